// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ID/EX control bundle, opcode constants and bubble value.
package cpu_pkg;
   // ALU_Op: 00 add, 01 sub/branch, 10 R-type, 11 immediate ALU
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_R   = 2'b10;
   localparam logic [1:0] ALU_IMM = 2'b11;
   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LW     = 7'b0000011;
   localparam logic [6:0] OPC_SW     = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   typedef struct packed {
      logic [1:0] EX_alu_op;
      logic       EX_alu_src;
      logic       M_mem_read;
      logic       M_mem_write;
      logic       M_branch;
      logic       WB_reg_write;
      logic       WB_mem_to_reg;
   } id_ex_control_t;
   localparam id_ex_control_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/id_decode.sv
// id_decode: combinational opcode decode into the EX control bundle plus
// operand-usage and illegal flags.
module id_decode
   import cpu_pkg::*;
(
   input  logic [6:0]     opcode,
   output id_ex_control_t ctrl,
   output logic           illegal,
   output logic           rs1_used,
   output logic           rs2_used
);
   always_comb begin
      ctrl = CTRL_BUBBLE;
      illegal = 1'b0;
      case (opcode)
         OPC_R: begin
            ctrl.EX_alu_op = ALU_R;
            ctrl.WB_reg_write = 1'b1;
         end
         OPC_OP_IMM: begin
            ctrl.EX_alu_op = ALU_IMM;
            ctrl.EX_alu_src = 1'b1;
            ctrl.WB_reg_write = 1'b1;
         end
         OPC_LW: begin
            ctrl.EX_alu_op = ALU_ADD;
            ctrl.EX_alu_src = 1'b1;
            ctrl.M_mem_read = 1'b1;
            ctrl.WB_reg_write = 1'b1;
            ctrl.WB_mem_to_reg = 1'b1;
         end
         OPC_SW: begin
            ctrl.EX_alu_op = ALU_ADD;
            ctrl.EX_alu_src = 1'b1;
            ctrl.M_mem_write = 1'b1;
         end
         OPC_BRANCH: begin
            ctrl.EX_alu_op = ALU_SUB;
            ctrl.M_branch = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end
   assign rs1_used = ~illegal;
   assign rs2_used = (opcode == OPC_R) | (opcode == OPC_SW) | (opcode == OPC_BRANCH);
endmodule

// File: rtl/id_ctrl_stage.sv
// id_ctrl_stage: ID-stage control with load-use hazard detection, the ID/EX
// pipeline register and saturating stall / illegal-instruction counters.
module id_ctrl_stage
   import cpu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [XLEN-1:0]   id_instr,
   input  logic              id_valid,
   input  logic              flush,
   output id_ex_control_t    ex_ctrl,
   output logic [REG_AW-1:0] ex_rd,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [2:0]        ex_funct3,
   output logic              ex_funct7_b5,
   output logic              ex_valid,
   output logic              stall,
   output logic              illegal,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  illegal_cnt
);
   id_ex_control_t    dec_ctrl, ctrl_d, ctrl_q;
   logic              dec_illegal, rs1_used, rs2_used, load;
   logic [REG_AW-1:0] rd, rs1, rs2, rd_d, rs1_d, rs2_d, rd_q, rs1_q, rs2_q;
   logic [2:0]        f3_d, f3_q;
   logic              f7_d, f7_q, valid_d, valid_q, ill_d, ill_q;
   logic [CNT_W-1:0]  scnt_d, scnt_q, icnt_d, icnt_q;
   logic              unused_instr_bits;
   assign unused_instr_bits = ^{id_instr[XLEN-1:31], id_instr[29:25]};
   id_decode u_dec (
      .opcode   (id_instr[6:0]),
      .ctrl     (dec_ctrl),
      .illegal  (dec_illegal),
      .rs1_used (rs1_used),
      .rs2_used (rs2_used)
   );
   assign rd  = REG_AW'(id_instr[11:7]);
   assign rs1 = REG_AW'(id_instr[19:15]);
   assign rs2 = REG_AW'(id_instr[24:20]);
   assign stall = id_valid & valid_q & ctrl_q.M_mem_read & (rd_q != '0) &
                  ((rs1_used & (rd_q == rs1)) | (rs2_used & (rd_q == rs2))) & ~flush;
   assign load = id_valid & ~flush & ~stall;
   // Anything that does not write a register carries rd=0 so it can never fake a hazard.
   always_comb begin
      valid_d = load;
      ctrl_d  = load ? dec_ctrl : CTRL_BUBBLE;
      ill_d   = load & dec_illegal;
      rd_d    = load && dec_ctrl.WB_reg_write ? rd : '0;
      rs1_d   = load ? rs1 : '0;
      rs2_d   = load ? rs2 : '0;
      f3_d    = load ? id_instr[14:12] : 3'b0;
      f7_d    = load & id_instr[30];
      scnt_d  = scnt_q + CNT_W'(stall & ~&scnt_q);
      icnt_d  = icnt_q + CNT_W'(ill_d & ~&icnt_q);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         ctrl_q  <= CTRL_BUBBLE;
         ill_q   <= 1'b0;
         rd_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         f3_q    <= 3'b0;
         f7_q    <= 1'b0;
         scnt_q  <= '0;
         icnt_q  <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         ill_q   <= ill_d;
         rd_q    <= rd_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         f3_q    <= f3_d;
         f7_q    <= f7_d;
         scnt_q  <= scnt_d;
         icnt_q  <= icnt_d;
      end
   end
   assign ex_ctrl      = ctrl_q;
   assign ex_rd        = rd_q;
   assign ex_rs1       = rs1_q;
   assign ex_rs2       = rs2_q;
   assign ex_funct3    = f3_q;
   assign ex_funct7_b5 = f7_q;
   assign ex_valid     = valid_q;
   assign illegal      = ill_q;
   assign stall_cnt    = scnt_q;
   assign illegal_cnt  = icnt_q;
endmodule
